// File: rtl/arb_pkg.sv
// Shared types and helpers for the grant-hold arbiter: FSM state encoding,
// default hold limit and index arithmetic used by the picker and the top.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_e;

   localparam int DEF_MAX_HOLD = 8;

   function automatic int owner_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // (a + b) mod n for operands already in [0, n), without a divider.
   function automatic int wrap_idx(input int a, input int b, input int n);
      int s;
      s = a + b;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage

// File: rtl/grant_hold_arbiter_pick.sv
// Combinational daisy-chain pick over a rotated request vector; the rotation
// turns fixed priority into round-robin when rr_en is set.
module priority_pick
   import arb_pkg::*;
#(
   parameter int N = 4,
   parameter int W = owner_w(N)
) (
   input  logic [0:N-1] elig,
   input  logic [W-1:0] start,
   input  logic         rr_en,
   output logic [0:N-1] onehot,
   output logic [W-1:0] idx,
   output logic         valid
);

   logic [W-1:0] base;
   logic [0:N-1] rot;
   logic [0:N-1] pick;
   logic [0:N]   blocked;

   assign base       = rr_en ? start : '0;
   assign blocked[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chain
         logic [W-1:0] src_idx;
         logic [W-1:0] back_idx;

         always_comb begin
            src_idx  = W'(wrap_idx(gi, int'(base), N));
            back_idx = W'(wrap_idx(gi, N - int'(base), N));
            if (int'(back_idx) >= N) begin
               back_idx = '0;
            end
         end

         assign rot[gi]         = elig[src_idx];
         assign pick[gi]        = rot[gi] & ~blocked[gi];
         assign blocked[gi + 1] = blocked[gi] | rot[gi];
         assign onehot[gi]      = pick[back_idx];
      end
   endgenerate

   always_comb begin
      idx = '0;
      for (int k = 0; k < N; k++) begin
         if (pick[k]) begin
            idx = W'(wrap_idx(k, int'(base), N));
         end
      end
   end

   assign valid = blocked[N];

endmodule

// File: rtl/grant_hold_arbiter.sv
// Shares one resource among N requesters: registered one-hot grant held until
// release or hold timeout, a dead cycle between owners, and per-requester lockout.
module grant_hold_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int HOLD_W   = 4,
   localparam int OW      = owner_w(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rr_en,
   input  logic [0:N-1]  req,
   output logic [0:N-1]  grant,
   output logic          busy,
   output logic [OW-1:0] owner,
   output logic          timeout
);

   localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
   localparam logic [OW-1:0]     LAST_RST   = OW'(N - 1);

   arb_state_e        state_q, state_d;
   logic [0:N-1]      grant_q, grant_d;
   logic              busy_q, busy_d;
   logic [OW-1:0]     owner_q, owner_d;
   logic              timeout_q, timeout_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [0:N-1]      mask_q, mask_d;
   logic [OW-1:0]     last_q, last_d;

   logic [0:N-1]      elig;
   logic [OW-1:0]     start_idx;
   logic [0:N-1]      pick_onehot;
   logic [OW-1:0]     pick_idx;
   logic              pick_valid;

   assign elig      = req & ~mask_q;
   assign start_idx = (last_q >= LAST_RST) ? '0 : last_q + 1'b1;

   priority_pick #(
      .N (N),
      .W (OW)
   ) u_pick (
      .elig   (elig),
      .start  (start_idx),
      .rr_en  (rr_en),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      busy_d    = busy_q;
      owner_d   = owner_q;
      timeout_d = 1'b0;
      hold_d    = hold_q;
      last_d    = last_q;
      // Lockout lifts only once the requester has let go of req.
      mask_d    = mask_q & req;

      case (state_q)
         IDLE, GAP: begin
            if (pick_valid) begin
               state_d = GRANT;
               grant_d = pick_onehot;
               owner_d = pick_idx;
               busy_d  = 1'b1;
               hold_d  = HOLD_W'(1);
            end else begin
               state_d = IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
            end
         end
         GRANT: begin
            if (!req[owner_q]) begin
               state_d = GAP;
               grant_d = '0;
               busy_d  = 1'b0;
               last_d  = owner_q;
            end else if ((MAX_HOLD != 0) && (hold_q == MAX_HOLD_C)) begin
               state_d         = GAP;
               grant_d         = '0;
               busy_d          = 1'b0;
               timeout_d       = 1'b1;
               mask_d[owner_q] = 1'b1;
               last_d          = owner_q;
            end else if (hold_q != '1) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         owner_q   <= '0;
         timeout_q <= 1'b0;
         hold_q    <= '0;
         mask_q    <= '0;
         last_q    <= LAST_RST;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         owner_q   <= owner_d;
         timeout_q <= timeout_d;
         hold_q    <= hold_d;
         mask_q    <= mask_d;
         last_q    <= last_d;
      end
   end

   assign grant   = grant_q;
   assign busy    = busy_q;
   assign owner   = owner_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_grant_hold_arbiter.sv
// Directed bench for grant_hold_arbiter (N=4, MAX_HOLD=8): stimulus queues the
// hand-computed response of each cycle, a monitor pops and compares it.
module tb_grant_hold_arbiter;

   logic       clk;
   logic       rst_n;
   logic       rr_en;
   logic [0:3] req;
   logic [0:3] grant;
   logic       busy;
   logic [1:0] owner;
   logic       timeout;

   typedef struct {
      logic [0:3] g;
      logic       b;
      logic [1:0] o;
      logic       t;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   event async_chk;

   grant_hold_arbiter #(
      .N        (4),
      .MAX_HOLD (8),
      .HOLD_W   (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rr_en   (rr_en),
      .req     (req),
      .grant   (grant),
      .busy    (busy),
      .owner   (owner),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100000");
      $fatal(1);
   end

   // Drive inputs for one cycle and queue what must be visible after the next edge.
   task automatic cyc(input logic r_n, input logic [0:3] r, input logic rr,
                      input logic [0:3] g, input logic b, input logic [1:0] o,
                      input logic t, input string tag);
      exp_t e;
      @(negedge clk);
      rst_n = r_n;
      req   = r;
      rr_en = rr;
      e = '{g: g, b: b, o: o, t: t, tag: tag};
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk or async_chk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || busy !== e.b || owner !== e.o || timeout !== e.t) begin
               $display("FAIL %s: got grant=%b busy=%b owner=%0d timeout=%b, required grant=%b busy=%b owner=%0d timeout=%b",
                        e.tag, grant, busy, owner, timeout, e.g, e.b, e.o, e.t);
            end else begin
               passed++;
               $display("ok   %s: grant=%b busy=%b owner=%0d timeout=%b",
                        e.tag, grant, busy, owner, timeout);
            end
         end
      end
   end

   initial begin : stimulus
      exp_t e;
      rst_n = 1'b0;
      req   = 4'b1111;
      rr_en = 1'b0;

      // Reset held with all requests up, then released.
      repeat (2) cyc(0, 4'b1111, 0, 4'b0000, 0, 2'd0, 0, "rst_hold");
      cyc(1, 4'b1111, 0, 4'b1000, 1, 2'd0, 0, "rst_release");
      cyc(1, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, "drop_gap");
      cyc(1, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, "idle");

      // Fixed priority, hold, release with GAP.
      cyc(1, 4'b0110, 0, 4'b0100, 1, 2'd1, 0, "fp_grant");
      repeat (2) cyc(1, 4'b0110, 0, 4'b0100, 1, 2'd1, 0, "fp_hold");
      cyc(1, 4'b0010, 0, 4'b0000, 0, 2'd1, 0, "fp_gap");
      cyc(1, 4'b0010, 0, 4'b0010, 1, 2'd2, 0, "fp_next");
      cyc(1, 4'b0000, 0, 4'b0000, 0, 2'd2, 0, "fp_rel");
      cyc(1, 4'b0000, 0, 4'b0000, 0, 2'd2, 0, "fp_idle");

      // Park last owner at 3 so the round-robin walk starts at 0.
      cyc(1, 4'b0001, 0, 4'b0001, 1, 2'd3, 0, "park3");
      cyc(1, 4'b0000, 0, 4'b0000, 0, 2'd3, 0, "park3_rel");

      // Round-robin: each owner holds 2 cycles, drops for 1.
      cyc(1, 4'b1111, 1, 4'b1000, 1, 2'd0, 0, "rr0");
      cyc(1, 4'b1111, 1, 4'b1000, 1, 2'd0, 0, "rr0_hold");
      cyc(1, 4'b0111, 1, 4'b0000, 0, 2'd0, 0, "rr0_gap");
      cyc(1, 4'b1111, 1, 4'b0100, 1, 2'd1, 0, "rr1");
      cyc(1, 4'b1111, 1, 4'b0100, 1, 2'd1, 0, "rr1_hold");
      cyc(1, 4'b1011, 1, 4'b0000, 0, 2'd1, 0, "rr1_gap");
      cyc(1, 4'b1111, 1, 4'b0010, 1, 2'd2, 0, "rr2");
      cyc(1, 4'b1111, 1, 4'b0010, 1, 2'd2, 0, "rr2_hold");
      cyc(1, 4'b1101, 1, 4'b0000, 0, 2'd2, 0, "rr2_gap");
      cyc(1, 4'b1111, 1, 4'b0001, 1, 2'd3, 0, "rr3");
      cyc(1, 4'b1111, 1, 4'b0001, 1, 2'd3, 0, "rr3_hold");
      cyc(1, 4'b1110, 1, 4'b0000, 0, 2'd3, 0, "rr3_gap");
      cyc(1, 4'b1111, 1, 4'b1000, 1, 2'd0, 0, "rr0_again");
      cyc(1, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, "rr_rel");
      cyc(1, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, "rr_idle");

      // Timeout after 8 granted cycles, then lockout until req[2] drops.
      cyc(1, 4'b0010, 0, 4'b0010, 1, 2'd2, 0, "to_grant");
      repeat (7) cyc(1, 4'b0010, 0, 4'b0010, 1, 2'd2, 0, "to_hold");
      cyc(1, 4'b0010, 0, 4'b0000, 0, 2'd2, 1, "to_pulse");
      repeat (3) cyc(1, 4'b0010, 0, 4'b0000, 0, 2'd2, 0, "to_locked");
      cyc(1, 4'b0000, 0, 4'b0000, 0, 2'd2, 0, "to_drop");
      cyc(1, 4'b0010, 0, 4'b0010, 1, 2'd2, 0, "to_regrant");
      repeat (7) cyc(1, 4'b0010, 0, 4'b0010, 1, 2'd2, 0, "to_hold2");
      cyc(1, 4'b0010, 0, 4'b0000, 0, 2'd2, 1, "to_pulse2");
      cyc(1, 4'b0110, 0, 4'b0100, 1, 2'd1, 0, "masked_skip");
      cyc(1, 4'b0110, 0, 4'b0100, 1, 2'd1, 0, "masked_hold");

      // Asynchronous reset between edges while requester 1 is granted.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      e = '{g: 4'b0000, b: 1'b0, o: 2'd0, t: 1'b0, tag: "arst_immediate"};
      sb.push_back(e);
      e = '{g: 4'b0000, b: 1'b0, o: 2'd0, t: 1'b0, tag: "arst_edge"};
      sb.push_back(e);
      -> async_chk;
      cyc(1, 4'b0010, 0, 4'b0010, 1, 2'd2, 0, "arst_mask_clear");

      // Release and new request on the same edge, rr_en flipped mid-grant.
      cyc(1, 4'b0000, 0, 4'b0000, 0, 2'd2, 0, "sim_rel2");
      cyc(1, 4'b1000, 0, 4'b1000, 1, 2'd0, 0, "sim_grant0");
      cyc(1, 4'b1000, 1, 4'b1000, 1, 2'd0, 0, "sim_rr_midgrant");
      cyc(1, 4'b0001, 1, 4'b0000, 0, 2'd0, 0, "sim_gap");
      cyc(1, 4'b0001, 1, 4'b0001, 1, 2'd3, 0, "sim_rr_pick3");
      cyc(1, 4'b0000, 0, 4'b0000, 0, 2'd3, 0, "sim_rel3");

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
